// File: rtl/tap_player.sv
// TAP tape image player: turns a byte image into pilot/sync/bit pulses on mic.
// Define TAP_TURBO_EN to add the turbo input, which halves every pulse except the pause.
module tap_player #(
    parameter int ADDR_W     = 16,
    parameter int PILOT_T    = 2168,
    parameter int SYNC1_T    = 667,
    parameter int SYNC2_T    = 735,
    parameter int BIT0_T     = 855,
    parameter int BIT1_T     = 1710,
    parameter int PILOT_HDR  = 8063,
    parameter int PILOT_DATA = 3223,
    parameter int PAUSE_T    = 3500000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              play,
    input  logic              rewind,
`ifdef TAP_TURBO_EN
    input  logic              turbo,
`endif
    input  logic [ADDR_W-1:0] tap_size,
    output logic [ADDR_W-1:0] tap_address,
    input  logic [7:0]        tap_data,
    output logic              mic,
    output logic              busy,
    output logic              block_done,
    output logic              eot
);

    function automatic int maxi(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_T = maxi(maxi(maxi(PILOT_T, SYNC1_T), maxi(SYNC2_T, BIT0_T)),
                                maxi(BIT1_T, PAUSE_T));
    localparam int CNT_W = $clog2(MAX_T + 1);
    localparam int PC_W  = $clog2(maxi(PILOT_HDR, PILOT_DATA) + 1);

    typedef enum logic [3:0] {
        IDLE, LEN_LO, LEN_HI, PILOT, SYNC1, SYNC2, BIT_HI, BIT_LO, PAUSE, EOT
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [PC_W-1:0]   prem;
    logic [15:0]       len;
    logic [7:0]        sh;
    logic [2:0]        bitn;
    logic              fresh;
    logic              lead;
    logic              fast;
    logic [ADDR_W:0]   addr_nx;
    logic [ADDR_W:0]   size_x;

`ifdef TAP_TURBO_EN
    assign fast = turbo;
`else
    assign fast = 1'b0;
`endif

    assign addr_nx = {1'b0, tap_address} + (ADDR_W+1)'(1);
    assign size_x  = {1'b0, tap_size};

    // Reload value for a pulse of t clocks; the pulse ends on the edge that sees cnt == 0.
    function automatic logic [CNT_W-1:0] span(input int t, input logic half);
        int v;
        v = half ? (t >> 1) : t;
        if (v < 1) v = 1;
        return CNT_W'(v - 1);
    endfunction

    function automatic logic [CNT_W-1:0] bit_span(input logic b, input logic half);
        return span(b ? BIT1_T : BIT0_T, half);
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            tap_address <= '0;
            mic         <= 1'b1;
            busy        <= 1'b0;
            block_done  <= 1'b0;
            eot         <= 1'b0;
            cnt         <= '0;
            prem        <= '0;
            len         <= '0;
            sh          <= '0;
            bitn        <= '0;
            fresh       <= 1'b0;
            lead        <= 1'b0;
        end else if (rewind) begin
            state       <= IDLE;
            tap_address <= '0;
            mic         <= 1'b1;
            busy        <= 1'b0;
            block_done  <= 1'b0;
            eot         <= 1'b0;
            cnt         <= '0;
            prem        <= '0;
            len         <= '0;
            sh          <= '0;
            bitn        <= '0;
            fresh       <= 1'b0;
            lead        <= 1'b0;
        end else begin
            block_done <= 1'b0;
            // tap_data is trustworthy once a full clock has passed since the last address move.
            fresh      <= 1'b1;
            if (play) begin
                case (state)
                    IDLE: begin
                        if (tap_address >= tap_size) begin
                            state <= EOT;
                            eot   <= 1'b1;
                            mic   <= 1'b1;
                        end else begin
                            state <= LEN_LO;
                            busy  <= 1'b1;
                        end
                    end
                    LEN_LO: if (fresh) begin
                        len[7:0]    <= tap_data;
                        tap_address <= tap_address + ADDR_W'(1);
                        fresh       <= 1'b0;
                        if (addr_nx >= size_x) begin
                            state <= EOT;
                            eot   <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= LEN_HI;
                        end
                    end
                    LEN_HI: if (fresh) begin
                        len[15:8]   <= tap_data;
                        tap_address <= tap_address + ADDR_W'(1);
                        fresh       <= 1'b0;
                        if ({tap_data, len[7:0]} == 16'd0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else if (addr_nx >= size_x) begin
                            state <= EOT;
                            eot   <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= PILOT;
                            lead  <= 1'b1;
                        end
                    end
                    PILOT: begin
                        if (lead) begin
                            // The flag byte picks the pilot length and is also the first byte sent.
                            if (fresh) begin
                                lead <= 1'b0;
                                sh   <= tap_data;
                                prem <= tap_data[7] ? PC_W'(PILOT_DATA - 1) : PC_W'(PILOT_HDR - 1);
                                cnt  <= span(PILOT_T, fast);
                                mic  <= 1'b1;
                            end
                        end else if (cnt != '0) begin
                            cnt <= cnt - CNT_W'(1);
                        end else if (prem == '0) begin
                            state <= SYNC1;
                            mic   <= 1'b1;
                            cnt   <= span(SYNC1_T, fast);
                        end else begin
                            prem <= prem - PC_W'(1);
                            mic  <= ~mic;
                            cnt  <= span(PILOT_T, fast);
                        end
                    end
                    SYNC1: begin
                        if (cnt != '0) begin
                            cnt <= cnt - CNT_W'(1);
                        end else begin
                            state <= SYNC2;
                            mic   <= 1'b0;
                            cnt   <= span(SYNC2_T, fast);
                        end
                    end
                    SYNC2: begin
                        if (cnt != '0) begin
                            cnt <= cnt - CNT_W'(1);
                        end else begin
                            state <= BIT_HI;
                            mic   <= 1'b1;
                            bitn  <= 3'd7;
                            cnt   <= bit_span(sh[7], fast);
                        end
                    end
                    BIT_HI: begin
                        if (cnt != '0) begin
                            cnt <= cnt - CNT_W'(1);
                        end else begin
                            state <= BIT_LO;
                            mic   <= 1'b0;
                            cnt   <= bit_span(sh[7], fast);
                        end
                    end
                    BIT_LO: begin
                        if (cnt != '0) begin
                            cnt <= cnt - CNT_W'(1);
                        end else if (bitn != 3'd0) begin
                            bitn  <= bitn - 3'd1;
                            sh    <= {sh[6:0], 1'b0};
                            state <= BIT_HI;
                            mic   <= 1'b1;
                            cnt   <= bit_span(sh[6], fast);
                            // Step to the next byte as bit 0 starts so it is readable when bit 0 ends.
                            if (bitn == 3'd1) begin
                                tap_address <= tap_address + ADDR_W'(1);
                                fresh       <= 1'b0;
                            end
                        end else begin
                            len <= len - 16'd1;
                            if (len == 16'd1) begin
                                block_done <= 1'b1;
                                state      <= PAUSE;
                                mic        <= 1'b0;
                                cnt        <= span(PAUSE_T, 1'b0);
                            end else if (tap_address >= tap_size) begin
                                state <= EOT;
                                eot   <= 1'b1;
                                busy  <= 1'b0;
                                mic   <= 1'b1;
                            end else begin
                                sh    <= tap_data;
                                bitn  <= 3'd7;
                                state <= BIT_HI;
                                mic   <= 1'b1;
                                cnt   <= bit_span(tap_data[7], fast);
                            end
                        end
                    end
                    PAUSE: begin
                        if (cnt != '0) begin
                            cnt <= cnt - CNT_W'(1);
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            mic   <= 1'b1;
                        end
                    end
                    EOT: begin
                        mic <= 1'b1;
                        eot <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tap_player.sv
// Scoreboard bench for tap_player: expected mic runs are queued, a monitor measures active-clock run lengths.
module tb_tap_player;

    localparam int PAUSE = 10;

    logic        clock = 1'b0;
    logic        reset;
    logic        play;
    logic        rewind;
    logic [15:0] tap_size;
    logic [15:0] tap_address;
    logic [7:0]  tap_data;
    logic        mic, busy, block_done, eot;
`ifdef TAP_TURBO_EN
    logic        turbo;
`endif

    logic [7:0]  mem [0:15];

    typedef struct { logic lvl; int len; } run_t;
    run_t exp_q[$];

    int  vectors = 0;
    int  miscompares = 0;
    int  bd_count = 0;
    bit  mon_on = 0;
    bit  mon_first = 0;
    int  tp, ts1, ts2, tb0, tb1;

    tap_player #(
        .ADDR_W(16), .PILOT_T(4), .SYNC1_T(2), .SYNC2_T(3), .BIT0_T(2), .BIT1_T(4),
        .PILOT_HDR(5), .PILOT_DATA(3), .PAUSE_T(PAUSE)
    ) dut (
        .clock(clock),
        .reset(reset),
        .play(play),
        .rewind(rewind),
`ifdef TAP_TURBO_EN
        .turbo(turbo),
`endif
        .tap_size(tap_size),
        .tap_address(tap_address),
        .tap_data(tap_data),
        .mic(mic),
        .busy(busy),
        .block_done(block_done),
        .eot(eot)
    );

    always #5 clock = ~clock;

    // Image memory with one clock of read latency.
    always @(posedge clock) tap_data <= mem[tap_address[3:0]];

    task automatic check(input string name, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    task automatic check_run(input logic lvl, input int len);
        run_t e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL run_unexpected: got level %0b for %0d clocks, required no further run", lvl, len);
        end else begin
            e = exp_q.pop_front();
            if (e.lvl !== lvl || e.len != len) begin
                miscompares++;
                $display("FAIL run: got level %0b for %0d clocks, required level %0b for %0d clocks",
                         lvl, len, e.lvl, e.len);
            end
        end
    endtask

    // Monitor: a clock counts toward a run only when play is high for the edge that ends it.
    initial begin : monitor
        logic prev;
        int   run;
        bit   skipping;
        prev = 1'b1;
        run = 0;
        skipping = 1'b1;
        forever begin
            @(negedge clock);
            #1;
            if (mon_first) begin
                prev = mic;
                run = 0;
                skipping = 1'b1;
                mon_first = 0;
            end else if (mon_on) begin
                if (mic !== prev) begin
                    if (skipping) skipping = 1'b0;
                    else check_run(prev, run);
                    prev = mic;
                    run = play ? 1 : 0;
                end else if (play) begin
                    run++;
                end
            end
            if (block_done === 1'b1) bd_count++;
        end
    end

    task automatic push_run(input logic l, input int n);
        run_t r;
        r.lvl = l;
        r.len = n;
        exp_q.push_back(r);
    endtask

    // Pilot pulse 0 merges into the leading high run, the last pilot pulse into SYNC1.
    task automatic push_pilot(input int np);
        for (int i = 1; i <= np - 2; i++) push_run((i % 2) == 0, tp);
        push_run(1'b1, tp + ts1);
        push_run(1'b0, ts2);
    endtask

    task automatic push_byte(input logic [7:0] b, input bit last);
        int t;
        for (int k = 7; k >= 0; k--) begin
            t = b[k] ? tb1 : tb0;
            push_run(1'b1, t);
            push_run(1'b0, (last && k == 0) ? t + PAUSE : t);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        play = 0;
        rewind = 0;
        reset = 1;
        repeat (2) @(negedge clock);
        reset = 0;
        @(negedge clock);
    endtask

    task automatic arm();
        mon_on = 1;
        mon_first = 1;
        bd_count = 0;
        @(negedge clock);
        #2;
    endtask

    task automatic wait_eot(input string name, input int exp_addr, input int exp_bd);
        bit seen;
        seen = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clock);
            if (eot === 1'b1) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: got no eot within 2000 clocks, required eot=1", name);
        end
        repeat (3) @(negedge clock);
        check({name, "_eot"}, eot, 1);
        check({name, "_busy"}, busy, 0);
        check({name, "_mic"}, mic, 1);
        check({name, "_addr"}, tap_address, exp_addr);
        check({name, "_runs_left"}, exp_q.size(), 0);
        check({name, "_block_done"}, bd_count, exp_bd);
        exp_q.delete();
    endtask

    task automatic load_img1();
        mem[0] = 8'h02; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'hA5;
        tap_size = 16'd4;
    endtask

    task automatic push_img1();
        push_pilot(5);
        push_byte(8'h00, 0);
        push_byte(8'hA5, 1);
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bit   found;
        logic pm;
        int   rises;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        tp = 4; ts1 = 2; ts2 = 3; tb0 = 2; tb1 = 4;
        reset = 1;
        play = 0;
        rewind = 0;
        tap_size = 16'd0;
`ifdef TAP_TURBO_EN
        turbo = 0;
`endif
        #12;
        check("reset_addr", tap_address, 0);
        check("reset_mic", mic, 1);
        check("reset_busy", busy, 0);
        check("reset_eot", eot, 0);
        check("reset_block_done", block_done, 0);
        @(negedge clock);
        reset = 0;

        // Empty image goes straight to end of tape.
        tap_size = 16'd0;
        arm();
        play = 1;
        wait_eot("empty", 0, 0);

        // Header block: flag 00 then A5.
        do_reset();
        load_img1();
        arm();
        push_img1();
        play = 1;
        wait_eot("img1", 4, 1);

        // Single-byte data block.
        do_reset();
        mem[0] = 8'h01; mem[1] = 8'h00; mem[2] = 8'h80;
        tap_size = 16'd3;
        arm();
        push_pilot(3);
        push_byte(8'h80, 1);
        play = 1;
        wait_eot("img2", 3, 1);

        // Zero-length block skipped, then 0xFF with a 7-clock freeze inside the bit-6 high pulse.
        do_reset();
        mem[0] = 8'h00; mem[1] = 8'h00; mem[2] = 8'h01; mem[3] = 8'h00; mem[4] = 8'hFF;
        tap_size = 16'd5;
        arm();
        push_pilot(3);
        push_byte(8'hFF, 1);
        play = 1;
        pm = 1'b1;
        rises = 0;
        for (int i = 0; i < 500 && rises < 3; i++) begin
            @(negedge clock);
            if (mic === 1'b1 && pm === 1'b0) rises++;
            pm = mic;
        end
        check("freeze_reached", rises, 3);
        @(negedge clock);
        @(negedge clock);
        play = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clock);
            check("freeze_mic", mic, 1);
        end
        play = 1;
        wait_eot("img3", 5, 1);

        // Rewind during pilot, then again from end of tape.
        do_reset();
        load_img1();
        mon_on = 0;
        play = 1;
        found = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (mic === 1'b0) begin
                found = 1;
                break;
            end
        end
        check("rw_pilot_reached", found, 1);
        rewind = 1;
        @(negedge clock);
        rewind = 0;
        check("rw1_addr", tap_address, 0);
        check("rw1_mic", mic, 1);
        check("rw1_busy", busy, 0);
        check("rw1_eot", eot, 0);
        mon_on = 1;
        mon_first = 1;
        bd_count = 0;
        push_img1();
        wait_eot("rw1_replay", 4, 1);
        @(negedge clock);
        rewind = 1;
        @(negedge clock);
        rewind = 0;
        check("rw2_addr", tap_address, 0);
        check("rw2_mic", mic, 1);
        check("rw2_busy", busy, 0);
        check("rw2_eot", eot, 0);
        mon_first = 1;
        bd_count = 0;
        push_img1();
        wait_eot("rw2_replay", 4, 1);

        // Asynchronous reset in the low half of bit 0 of the first byte.
        do_reset();
        load_img1();
        mon_on = 0;
        play = 1;
        found = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (tap_address == 16'd3 && mic === 1'b0) begin
                found = 1;
                break;
            end
        end
        check("areset_reached", found, 1);
        check("areset_before_busy", busy, 1);
        #2;
        reset = 1;
        #1;
        check("areset_mic", mic, 1);
        check("areset_addr", tap_address, 0);
        check("areset_busy", busy, 0);
        check("areset_eot", eot, 0);
        check("areset_block_done", block_done, 0);
        @(negedge clock);
        reset = 0;
        play = 0;

`ifdef TAP_TURBO_EN
        // Turbo halves every pulse except the pause.
        do_reset();
        load_img1();
        turbo = 1;
        tp = 2; ts1 = 1; ts2 = 1; tb0 = 1; tb1 = 2;
        arm();
        push_img1();
        play = 1;
        wait_eot("turbo", 4, 1);
        turbo = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
